// File: rtl/exec_pkg.sv
// Shared constants for the arithmetic execution port and its divider.
package exec_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned FT_W   = 2;
  localparam int unsigned STAT_W = 2;
  localparam int unsigned ST_W   = 2;
  localparam int unsigned CNT_W  = 4;

  // Opcodes executed when functionType is ARITH; everything else is a NOP.
  localparam logic [OP_W-1:0] OP_NOP  = 7'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 7'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 7'd2;
  localparam logic [OP_W-1:0] OP_AND  = 7'd3;
  localparam logic [OP_W-1:0] OP_OR   = 7'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 7'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 7'd6;
  localparam logic [OP_W-1:0] OP_SHL  = 7'd7;
  localparam logic [OP_W-1:0] OP_SHR  = 7'd8;
  localparam logic [OP_W-1:0] OP_MUL  = 7'd9;
  localparam logic [OP_W-1:0] OP_DIV  = 7'd10;
  localparam logic [OP_W-1:0] OP_MOD  = 7'd11;
  localparam logic [OP_W-1:0] OP_ADDC = 7'd12;

  localparam logic [FT_W-1:0] FT_ARITH = 2'd0;

  localparam int unsigned STAT_CARRY = 0;
  localparam int unsigned STAT_ZERO  = 1;

  // Port FSM encoding.
  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_MUL2    = 2'd1;
  localparam logic [ST_W-1:0] ST_DIV_RUN = 2'd2;

  // Builds the status word {zero, carry} for a writeback value.
  function automatic logic [STAT_W-1:0] make_status(input logic carry,
                                                    input logic [DATA_W-1:0] val);
    logic [STAT_W-1:0] st;
    st             = '0;
    st[STAT_CARRY] = carry;
    st[STAT_ZERO]  = (val == '0);
    return st;
  endfunction

endpackage

// File: rtl/div_unit.sv
// 16-bit unsigned restoring divider: one quotient bit per clock, 16 clocks.
// The final step's results are presented combinationally alongside done so the
// caller can register them on the same edge the last bit is produced.
module div_unit
  import exec_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              done_c_o,
  output logic [DATA_W-1:0] quotient_c_o,
  output logic [DATA_W-1:0] remainder_c_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  logic              running_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;

  logic [DATA_W:0]   partial_c;
  logic              fits_c;
  logic [DATA_W-1:0] rem_n_c;
  logic [DATA_W-1:0] quo_n_c;

  // One restoring step: shift next dividend bit into the partial remainder.
  always_comb begin
    partial_c = {rem_q, quo_q[DATA_W-1]};
    fits_c    = (partial_c >= {1'b0, dvs_q});
    rem_n_c   = fits_c ? (partial_c[DATA_W-1:0] - dvs_q) : partial_c[DATA_W-1:0];
    quo_n_c   = {quo_q[DATA_W-2:0], fits_c};
  end

  assign done_c_o      = running_q && (count_q == CNT_LAST);
  assign quotient_c_o  = quo_n_c;
  assign remainder_c_o = rem_n_c;

  // Iteration state; abort and reset both return to idle with a cleared count.
  always_ff @(posedge clock_i) begin
    if (reset_i || abort_i) begin
      running_q <= 1'b0;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
    end else if (start_i) begin
      running_q <= 1'b1;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= dividend_i;
      dvs_q     <= divisor_i;
    end else if (running_q) begin
      rem_q     <= rem_n_c;
      quo_q     <= quo_n_c;
      count_q   <= count_q + CNT_W'(1);
      running_q <= (count_q != CNT_LAST);
    end
  end

endmodule

// File: rtl/exec_arith_port.sv
// Arithmetic execution port: single-cycle ALU ops, 2-cycle multiply and a
// 16-step divider, driving the register-file writeback bus.
module exec_arith_port
  import exec_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              enable_i,
  input  logic              wb_i,
  input  logic [OP_W-1:0]   opCode_i,
  input  logic [FT_W-1:0]   functionType_i,
  input  logic [ADDR_W-1:0] regAddr_i,
  input  logic [DATA_W-1:0] primOperand_i,
  input  logic [DATA_W-1:0] secOperand_i,
  input  logic [STAT_W-1:0] operationStatus_i,
  output logic              busy_o,
  output logic              wb_o,
  output logic [ADDR_W-1:0] wbAddr_o,
  output logic [DATA_W-1:0] wbVal_o,
  output logic [STAT_W-1:0] operationStatus_o
);

  logic [ST_W-1:0]   state_q,    state_d;
  logic              busy_q,     busy_d;
  logic              wb_q,       wb_d;
  logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
  logic [DATA_W-1:0] wb_val_q,   wb_val_d;
  logic [STAT_W-1:0] status_q,   status_d;
  logic              pend_wb_q,  pend_wb_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_mod_q, pend_mod_d;
  logic [DATA_W-1:0] opa_q,      opa_d;
  logic [DATA_W-1:0] opb_q,      opb_d;

  logic              alu_exec_c;
  logic [DATA_W-1:0] alu_val_c;
  logic              alu_carry_c;
  logic [DATA_W:0]   shl_ext_c;
  logic [DATA_W:0]   shr_ext_c;
  logic [DATA_W-1:0] mul_val_c;
  logic [DATA_W-1:0] div_val_c;
  logic              div_zero_c;
  logic              div_start_c;
  logic              div_done_c;
  logic [DATA_W-1:0] div_quo_c;
  logic [DATA_W-1:0] div_rem_c;
  logic              unused_status_c;

  assign unused_status_c = operationStatus_i[STAT_ZERO];

  div_unit u_div (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .start_i       (div_start_c),
    .abort_i       (flush_i),
    .dividend_i    (primOperand_i),
    .divisor_i     (secOperand_i),
    .done_c_o      (div_done_c),
    .quotient_c_o  (div_quo_c),
    .remainder_c_o (div_rem_c)
  );

  // Shift helpers: the extra bit catches the last bit shifted out.
  assign shl_ext_c = {1'b0, primOperand_i} << secOperand_i[3:0];
  assign shr_ext_c = {primOperand_i, 1'b0} >> secOperand_i[3:0];

  // Single-cycle result for the incoming instruction; alu_exec_c marks those ops.
  always_comb begin
    alu_exec_c  = 1'b1;
    alu_val_c   = '0;
    alu_carry_c = 1'b0;
    case (opCode_i)
      OP_ADD:  {alu_carry_c, alu_val_c} = {1'b0, primOperand_i} + {1'b0, secOperand_i};
      OP_ADDC: {alu_carry_c, alu_val_c} = {1'b0, primOperand_i} + {1'b0, secOperand_i}
                                          + {{DATA_W{1'b0}}, operationStatus_i[STAT_CARRY]};
      OP_SUB: begin
        alu_val_c   = primOperand_i - secOperand_i;
        alu_carry_c = (primOperand_i < secOperand_i);
      end
      OP_AND:  alu_val_c = primOperand_i & secOperand_i;
      OP_OR:   alu_val_c = primOperand_i | secOperand_i;
      OP_XOR:  alu_val_c = primOperand_i ^ secOperand_i;
      OP_NOT:  alu_val_c = ~primOperand_i;
      OP_SHL: begin
        alu_val_c   = shl_ext_c[DATA_W-1:0];
        alu_carry_c = shl_ext_c[DATA_W];
      end
      OP_SHR: begin
        alu_val_c   = shr_ext_c[DATA_W:1];
        alu_carry_c = shr_ext_c[0];
      end
      default: alu_exec_c = 1'b0;
    endcase
  end

  // Multi-cycle results from the captured operands.
  assign mul_val_c  = opa_q * opb_q;
  assign div_zero_c = (opb_q == '0);
  assign div_val_c  = div_zero_c ? (pend_mod_q ? opa_q : {DATA_W{1'b1}})
                                 : (pend_mod_q ? div_rem_c : div_quo_c);

  // Next-state and writeback selection.
  always_comb begin
    state_d     = state_q;
    wb_d        = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_val_d    = wb_val_q;
    status_d    = status_q;
    pend_wb_d   = pend_wb_q;
    pend_addr_d = pend_addr_q;
    pend_mod_d  = pend_mod_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    div_start_c = 1'b0;

    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_i && (functionType_i == FT_ARITH)) begin
            if (alu_exec_c) begin
              wb_d = wb_i;
              if (wb_i) begin
                wb_addr_d = regAddr_i;
                wb_val_d  = alu_val_c;
                status_d  = make_status(alu_carry_c, alu_val_c);
              end
            end else if ((opCode_i == OP_MUL) || (opCode_i == OP_DIV) ||
                         (opCode_i == OP_MOD)) begin
              pend_wb_d   = wb_i;
              pend_addr_d = regAddr_i;
              pend_mod_d  = (opCode_i == OP_MOD);
              opa_d       = primOperand_i;
              opb_d       = secOperand_i;
              if (opCode_i == OP_MUL) begin
                state_d = ST_MUL2;
              end else begin
                state_d     = ST_DIV_RUN;
                div_start_c = 1'b1;
              end
            end
          end
        end
        ST_MUL2: begin
          state_d = ST_IDLE;
          wb_d    = pend_wb_q;
          if (pend_wb_q) begin
            wb_addr_d = pend_addr_q;
            wb_val_d  = mul_val_c;
            status_d  = make_status(1'b0, mul_val_c);
          end
        end
        ST_DIV_RUN: begin
          if (div_done_c) begin
            state_d = ST_IDLE;
            wb_d    = pend_wb_q;
            if (pend_wb_q) begin
              wb_addr_d = pend_addr_q;
              wb_val_d  = div_val_c;
              status_d  = make_status(div_zero_c, div_val_c);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      wb_q        <= 1'b0;
      wb_addr_q   <= '0;
      wb_val_q    <= '0;
      status_q    <= '0;
      pend_wb_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_mod_q  <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      wb_q        <= wb_d;
      wb_addr_q   <= wb_addr_d;
      wb_val_q    <= wb_val_d;
      status_q    <= status_d;
      pend_wb_q   <= pend_wb_d;
      pend_addr_q <= pend_addr_d;
      pend_mod_q  <= pend_mod_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
    end
  end

  assign busy_o            = busy_q;
  assign wb_o              = wb_q;
  assign wbAddr_o          = wb_addr_q;
  assign wbVal_o           = wb_val_q;
  assign operationStatus_o = status_q;

endmodule

// File: tb/tb_exec_arith_port.sv
// Scoreboard bench for exec_arith_port: driver pushes expected writebacks,
// a negedge monitor pops and compares them.
module tb_exec_arith_port;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        wb_i = 1'b0;
  logic [6:0]  opCode_i = '0;
  logic [1:0]  functionType_i = '0;
  logic [4:0]  regAddr_i = '0;
  logic [15:0] primOperand_i = '0;
  logic [15:0] secOperand_i = '0;
  logic [1:0]  operationStatus_i = '0;
  logic        busy_o;
  logic        wb_o;
  logic [4:0]  wbAddr_o;
  logic [15:0] wbVal_o;
  logic [1:0]  operationStatus_o;

  always #5 clk = ~clk;

  exec_arith_port dut (
    .clock_i           (clk),
    .reset_i           (reset_i),
    .flush_i           (flush_i),
    .enable_i          (enable_i),
    .wb_i              (wb_i),
    .opCode_i          (opCode_i),
    .functionType_i    (functionType_i),
    .regAddr_i         (regAddr_i),
    .primOperand_i     (primOperand_i),
    .secOperand_i      (secOperand_i),
    .operationStatus_i (operationStatus_i),
    .busy_o            (busy_o),
    .wb_o              (wb_o),
    .wbAddr_o          (wbAddr_o),
    .wbVal_o           (wbVal_o),
    .operationStatus_o (operationStatus_o)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [15:0] val;
    logic [1:0]  st;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          mon_on = 1'b0;
  logic [4:0]  last_addr = '0;
  logic [15:0] last_val = '0;
  logic [1:0]  last_st = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: plain integer arithmetic on the opcode's meaning.
  task automatic model(input int op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, output logic [15:0] v, output logic c);
    int unsigned ua, ub, n, r;
    ua = a; ub = b; n = ub % 16; r = 0; v = '0; c = 1'b0;
    case (op)
      1:  begin r = ua + ub;       v = 16'(r); c = (r > 65535); end
      2:  begin v = 16'(ua - ub);  c = (ua < ub); end
      3:  v = a & b;
      4:  v = a | b;
      5:  v = a ^ b;
      6:  v = ~a;
      7:  begin r = ua << n; v = 16'(r); c = ((r >> 16) % 2) == 1; end
      8:  begin v = 16'(ua >> n); c = (n != 0) && (((ua >> (n - 1)) % 2) == 1); end
      9:  begin r = ua * ub; v = 16'(r); end
      10: begin if (ub == 0) begin v = 16'hFFFF; c = 1'b1; end else v = 16'(ua / ub); end
      11: begin if (ub == 0) begin v = a; c = 1'b1; end else v = 16'(ua % ub); end
      12: begin r = ua + ub + (cin ? 1 : 0); v = 16'(r); c = (r > 65535); end
      default: ;
    endcase
  endtask

  // Monitor: every writeback must match the oldest expectation; otherwise outputs hold.
  always @(negedge clk) begin
    if (mon_on) begin
      if (wb_o === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_wb", {31'd0, wb_o}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("wb_cycle", cyc, mon_e.cyc);
          check("wb_addr", {27'd0, wbAddr_o}, {27'd0, mon_e.addr});
          check("wb_val", {16'd0, wbVal_o}, {16'd0, mon_e.val});
          check("wb_status", {30'd0, operationStatus_o}, {30'd0, mon_e.st});
          last_addr = mon_e.addr;
          last_val  = mon_e.val;
          last_st   = mon_e.st;
        end
      end else begin
        check("wb_low", {31'd0, wb_o}, 32'd0);
        check("hold_val", {16'd0, wbVal_o}, {16'd0, last_val});
        check("hold_addr", {27'd0, wbAddr_o}, {27'd0, last_addr});
        check("hold_status", {30'd0, operationStatus_o}, {30'd0, last_st});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Issue one instruction (called at posedge+1) and walk through its busy period.
  task automatic issue(input int op, input logic [1:0] ft, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] addr, input logic wbreq,
                       input logic cin, input bit junk);
    logic [15:0] v;
    logic        c;
    int          busy_n;
    exp_t        e;
    enable_i = 1'b1; opCode_i = 7'(op); functionType_i = ft; primOperand_i = a;
    secOperand_i = b; regAddr_i = addr; wb_i = wbreq; operationStatus_i = {1'b0, cin};
    @(negedge clk);
    check("idle_before_issue", {31'd0, busy_o}, 32'd0);
    @(posedge clk); #1;
    enable_i = 1'b0;
    busy_n = (ft != 0) ? 0 : (op == 9) ? 1 : (op == 10 || op == 11) ? 16 : 0;
    if (ft == 0 && op >= 1 && op <= 12 && wbreq) begin
      model(op, a, b, cin, v, c);
      e.cyc = cyc + busy_n; e.addr = addr; e.val = v; e.st = {v == 16'd0, c};
      sb.push_back(e);
    end
    for (int k = 0; k < busy_n; k++) begin
      if (junk) begin
        enable_i = 1'b1; opCode_i = 7'd1; functionType_i = 2'd0; wb_i = 1'b1;
        primOperand_i = 16'($urandom); regAddr_i = 5'($urandom);
      end
      @(negedge clk);
      check("busy_high", {31'd0, busy_o}, 32'd1);
      @(posedge clk); #1;
    end
    enable_i = 1'b0;
  endtask

  // Start a DIV and kill it with flush or reset in cycle N+at.
  task automatic abort_div(input logic [15:0] a, input logic [15:0] b, input int at,
                           input bit use_reset);
    enable_i = 1'b1; opCode_i = 7'd10; functionType_i = 2'd0; primOperand_i = a;
    secOperand_i = b; regAddr_i = 5'd3; wb_i = 1'b1;
    @(posedge clk); #1;
    enable_i = 1'b0;
    for (int k = 1; k < at; k++) begin
      @(negedge clk);
      check("abort_busy_high", {31'd0, busy_o}, 32'd1);
      @(posedge clk); #1;
    end
    if (use_reset) reset_i = 1'b1; else flush_i = 1'b1;
    @(posedge clk); #1;
    if (use_reset) begin
      last_addr = '0; last_val = '0; last_st = '0;
      @(negedge clk);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_wb", {31'd0, wb_o}, 32'd0);
      check("rst_addr", {27'd0, wbAddr_o}, 32'd0);
      check("rst_val", {16'd0, wbVal_o}, 32'd0);
      check("rst_status", {30'd0, operationStatus_o}, 32'd0);
      @(posedge clk); #1;
      reset_i = 1'b0;
    end else begin
      flush_i = 1'b0;
    end
    @(negedge clk);
    check("abort_busy_low", {31'd0, busy_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   op;
    logic [1:0] ft;
    logic [15:0] a, b;
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    @(negedge clk);
    check("init_busy", {31'd0, busy_o}, 32'd0);
    check("init_val", {16'd0, wbVal_o}, 32'd0);
    check("init_status", {30'd0, operationStatus_o}, 32'd0);
    reset_i = 1'b0;
    @(posedge clk); #1;

    issue(1, 2'd0, 16'hFFFF, 16'h0001, 5'd5, 1'b1, 1'b0, 1'b0);
    issue(12, 2'd0, 16'h0001, 16'h0001, 5'd6, 1'b1, 1'b1, 1'b0);
    issue(9, 2'd0, 16'h0100, 16'h0101, 5'd7, 1'b1, 1'b0, 1'b1);
    issue(10, 2'd0, 16'd1000, 16'd7, 5'd8, 1'b1, 1'b0, 1'b1);
    issue(11, 2'd0, 16'd1000, 16'd7, 5'd9, 1'b1, 1'b0, 1'b0);
    issue(10, 2'd0, 16'd5, 16'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    issue(11, 2'd0, 16'd5, 16'd0, 5'd11, 1'b1, 1'b0, 1'b0);
    abort_div(16'd1000, 16'd7, 8, 1'b0);
    issue(8, 2'd0, 16'h8001, 16'd1, 5'd12, 1'b1, 1'b0, 1'b0);

    // Flush wins over a simultaneous enable.
    flush_i = 1'b1; enable_i = 1'b1; opCode_i = 7'd1; functionType_i = 2'd0;
    primOperand_i = 16'd3; secOperand_i = 16'd4; regAddr_i = 5'd13; wb_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; enable_i = 1'b0;
    idle(2);

    issue(7, 2'd0, 16'h1234, 16'd4, 5'd14, 1'b1, 1'b0, 1'b0);
    abort_div(16'd999, 16'd3, 5, 1'b1);
    idle(3);

    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 18);
      ft = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      a  = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 20));
        default: b = 16'($urandom);
      endcase
      issue(op, ft, a, b, 5'($urandom), ($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    idle(5);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
